ncl_ripple_adder: RTL

//  Parametrised successor to the dual-rail NCL half adder. Clocked WIDTH-bit adder with

---
 rtl/ncl_ripple_adder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ncl_ripple_adder.sv
// Clocked dual-rail NCL ripple adder with a four-phase completion handshake, resolving BPC bits per cycle.
// Optional macro NCL_CARRYIN_EN adds a dual-rail carry-in port (full-adder semantics).
module ncl_ripple_adder #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic                 clk,
    input  logic                 init_n,
`ifdef NCL_CARRYIN_EN
    input  logic [1:0]           cin,
`endif
    input  logic [2*WIDTH-1:0]   A,
    input  logic [2*WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0]   sum,
    output logic [1:0]           carryout,
    input  logic                 sumCOMP,
    input  logic                 carryCOMP,
    output logic                 ACOMP,
    output logic                 BCOMP,
    output logic                 err
);

    localparam int IW = $clog2(WIDTH + BPC + 1);

    typedef enum logic [1:0] {
        WAIT_DATA = 2'd0,
        RIPPLE    = 2'd1,
        DRIVE     = 2'd2,
        HOLD_DATA = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, s_q, s_d;
    logic                 carry_q, carry_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [2*WIDTH-1:0]   sum_q, sum_d;
    logic [1:0]           cout_q, cout_d;
    logic                 acomp_q, acomp_d;
    logic                 err_q, err_d;
    logic                 scomp_prev_q, ccomp_prev_q;

    logic [WIDTH-1:0]     a_t_s, a_f_s, b_t_s, b_f_s;
    logic                 cin_data_s, cin_null_s, cin_ill_s, cin_bin_s;
    logic                 in_data_s, in_null_s, in_illegal_s;
    logic [WIDTH:0]       c_s;
    logic [WIDTH-1:0]     in_slice_s, slice_sum_s;
    logic [IW-1:0]        idx_end_s;
    logic [2*WIDTH-1:0]   enc_s;

`ifdef NCL_CARRYIN_EN
    assign cin_data_s = cin[1] ^ cin[0];
    assign cin_null_s = ~(cin[1] | cin[0]);
    assign cin_ill_s  = cin[1] & cin[0];
    assign cin_bin_s  = cin[1];
`else
    assign cin_data_s = 1'b1;
    assign cin_null_s = 1'b1;
    assign cin_ill_s  = 1'b0;
    assign cin_bin_s  = 1'b0;
`endif

    assign idx_end_s = idx_q + IW'(BPC);

    // Rail split, slice-masked carry chain and dual-rail encoding of the stored sum.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign a_t_s[i]       = A[2*i+1];
        assign a_f_s[i]       = A[2*i];
        assign b_t_s[i]       = B[2*i+1];
        assign b_f_s[i]       = B[2*i];
        assign in_slice_s[i]  = (idx_q <= IW'(i)) && (IW'(i) < idx_end_s);
        assign slice_sum_s[i] = in_slice_s[i] ? (a_q[i] ^ b_q[i] ^ c_s[i]) : s_q[i];
        assign c_s[i+1]       = in_slice_s[i] ? ((a_q[i] & b_q[i]) | (c_s[i] & (a_q[i] ^ b_q[i])))
                                              : c_s[i];
        assign enc_s[2*i+1]   = s_q[i];
        assign enc_s[2*i]     = ~s_q[i];
    end
    assign c_s[0] = carry_q;

    assign in_data_s    = (&(a_t_s ^ a_f_s)) & (&(b_t_s ^ b_f_s)) & cin_data_s;
    assign in_null_s    = ~(|A) & ~(|B) & cin_null_s;
    assign in_illegal_s = (|(a_t_s & a_f_s)) | (|(b_t_s & b_f_s)) | cin_ill_s;

    // Next-state, datapath and handshake logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        acomp_d = acomp_q;
        case (state_q)
            WAIT_DATA: begin
                if (in_data_s && !sumCOMP && !carryCOMP) begin
                    a_d     = a_t_s;
                    b_d     = b_t_s;
                    s_d     = '0;
                    carry_d = cin_bin_s;
                    idx_d   = '0;
                    state_d = RIPPLE;
                end else begin
                    state_d = WAIT_DATA;
                end
            end
            RIPPLE: begin
                s_d     = slice_sum_s;
                carry_d = c_s[WIDTH];
                idx_d   = idx_end_s;
                if (idx_end_s >= IW'(WIDTH)) begin
                    state_d = DRIVE;
                end else begin
                    state_d = RIPPLE;
                end
            end
            DRIVE: begin
                sum_d   = enc_s;
                cout_d  = carry_q ? 2'b10 : 2'b01;
                acomp_d = 1'b1;
                state_d = HOLD_DATA;
            end
            HOLD_DATA: begin
                if (in_null_s && sumCOMP && carryCOMP) begin
                    sum_d   = '0;
                    cout_d  = 2'b00;
                    acomp_d = 1'b0;
                    state_d = WAIT_DATA;
                end else begin
                    state_d = HOLD_DATA;
                end
            end
            default: begin
                state_d = WAIT_DATA;
            end
        endcase
    end

    // Sticky error: illegal pairs, operands dropping mid-computation, completion rising onto NULL outputs.
    always_comb begin
        err_d = err_q | in_illegal_s
              | (((state_q == RIPPLE) || (state_q == DRIVE)) && !in_data_s)
              | (((sumCOMP && !scomp_prev_q) || (carryCOMP && !ccomp_prev_q)) && (cout_q == 2'b00));
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!init_n) begin
            state_q      <= WAIT_DATA;
            a_q          <= '0;
            b_q          <= '0;
            s_q          <= '0;
            carry_q      <= 1'b0;
            idx_q        <= '0;
            sum_q        <= '0;
            cout_q       <= 2'b00;
            acomp_q      <= 1'b0;
            err_q        <= 1'b0;
            scomp_prev_q <= 1'b0;
            ccomp_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            s_q          <= s_d;
            carry_q      <= carry_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            cout_q       <= cout_d;
            acomp_q      <= acomp_d;
            err_q        <= err_d;
            scomp_prev_q <= sumCOMP;
            ccomp_prev_q <= carryCOMP;
        end
    end

    assign sum      = sum_q;
    assign carryout = cout_q;
    assign ACOMP    = acomp_q;
    assign BCOMP    = acomp_q;
    assign err      = err_q;

endmodule
